// File: rtl/load_port_responder.sv
// Load-port responder: accepts load requests, waits for the physical tag,
// reads a 64-bit word from a preloadable backing store and returns it after
// a fixed latency. Flags protocol violations with a sticky error bit.

package load_port_responder_pkg;

  localparam int unsigned IdxW  = 12;
  localparam int unsigned TagW  = 44;
  localparam int unsigned DataW = 64;
  localparam int unsigned BeW   = DataW / 8;

  // Request from the load unit
  typedef struct packed {
    logic [IdxW-1:0]  address_index;
    logic [TagW-1:0]  address_tag;
    logic [DataW-1:0] data_wdata;
    logic             data_req;
    logic             data_we;
    logic [BeW-1:0]   data_be;
    logic [1:0]       data_size;
    logic             kill_req;
    logic             tag_valid;
  } dcache_req_i_t;

  // Response to the load unit
  typedef struct packed {
    logic             data_gnt;
    logic             data_rvalid;
    logic [1:0]       data_rid;
    logic [DataW-1:0] data_rdata;
  } dcache_req_o_t;

endpackage

module load_port_responder
  import load_port_responder_pkg::*;
#(
  parameter int unsigned MemWords = 256,
  parameter int unsigned Latency  = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  dcache_req_i_t               req_port_i,
  output dcache_req_o_t               req_port_o,
  input  logic                        gnt_block_i,
  input  logic                        preload_we_i,
  input  logic [$clog2(MemWords)-1:0] preload_addr_i,
  input  logic [63:0]                 preload_data_i,
  output logic                        protocol_err_o
);

  localparam int unsigned WordAw = $clog2(MemWords);
  localparam int unsigned AddrW  = TagW + IdxW;
  localparam int unsigned OffW   = 3;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_TAG = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              err_q, err_d;

  logic              req_ok_c;
  logic              gnt_c;
  logic              accept_c;
  logic              err_set_c;

  logic [AddrW-1:0]  addr_c;
  logic [WordAw-1:0] rd_word_c;
  logic [DataW-1:0]  rd_data_c;

  logic [DataW-1:0]  mem_q [MemWords];

  logic [Latency-1:0] vld_q, vld_d;
  logic [DataW-1:0]   dat_q [Latency];
  logic [DataW-1:0]   dat_d [Latency];

  logic               unused_c;

  // A request is grantable only if it is a load, not blocked and not in reset
  assign req_ok_c = req_port_i.data_req && !req_port_i.data_we &&
                    !gnt_block_i && !rst_i;

  // Full address from the incoming tag and the index captured at grant
  assign addr_c    = {req_port_i.address_tag, idx_q};
  assign rd_word_c = addr_c[OffW +: WordAw];
  assign rd_data_c = mem_q[rd_word_c];

  // Next-state, grant, tag acceptance and violation detection
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gnt_c     = 1'b0;
    accept_c  = 1'b0;
    err_set_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_port_i.tag_valid || req_port_i.kill_req) begin
          err_set_c = 1'b1;
        end
        if (req_ok_c) begin
          gnt_c   = 1'b1;
          state_d = WAIT_TAG;
          idx_d   = req_port_i.address_index;
        end
      end
      WAIT_TAG: begin
        if (req_port_i.kill_req || req_port_i.tag_valid) begin
          // Kill wins over tag: the captured request is dropped silently
          accept_c = !req_port_i.kill_req;
          gnt_c    = req_ok_c;
          state_d  = req_ok_c ? WAIT_TAG : IDLE;
          if (req_ok_c) begin
            idx_d = req_port_i.address_index;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (req_port_i.data_req && req_port_i.data_we) begin
      err_set_c = 1'b1;
    end
  end

  assign err_d = err_q | err_set_c;

  // Response pipeline shift: new entry enters stage 0, data zeroed when idle
  always_comb begin
    vld_d[0] = accept_c;
    dat_d[0] = accept_c ? rd_data_c : '0;
    for (int i = 1; i < int'(Latency); i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  // Control state, captured index, sticky error and pipeline valids
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
    end
  end

  // Pipeline data path; qualified by the valids so needs no reset
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(Latency); i++) begin
      dat_q[i] <= dat_d[i];
    end
  end

  // Backing store: preload write port, survives reset, read is combinational
  always_ff @(posedge clk_i) begin
    if (preload_we_i) begin
      mem_q[preload_addr_i] <= preload_data_i;
    end
  end

  // Response port: only gnt, rvalid and rdata are driven
  always_comb begin
    req_port_o             = '0;
    req_port_o.data_gnt    = gnt_c;
    req_port_o.data_rvalid = vld_q[Latency-1];
    req_port_o.data_rdata  = vld_q[Latency-1] ? dat_q[Latency-1] : '0;
  end

  assign protocol_err_o = err_q;

  // Request fields the responder deliberately ignores
  assign unused_c = ^{req_port_i.data_wdata, req_port_i.data_be,
                      req_port_i.data_size, addr_c};

endmodule

// File: tb/tb_load_port_responder.sv
// Self-checking bench for load_port_responder: directed tables and
// sequences plus randomized traffic against a transaction-level model.

module tb_load_port_responder;
  import load_port_responder_pkg::*;

  localparam int unsigned MEM = 256;
  localparam int unsigned LAT = 2;

  logic          clk;
  logic          rst;
  dcache_req_i_t req_i;
  dcache_req_o_t req_o;
  logic          blk;
  logic          pwe;
  logic [7:0]    paddr;
  logic [63:0]   pdata;
  logic          perr;

  load_port_responder #(.MemWords(MEM), .Latency(LAT)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_port_i     (req_i),
    .req_port_o     (req_o),
    .gnt_block_i    (blk),
    .preload_we_i   (pwe),
    .preload_addr_i (paddr),
    .preload_data_i (pdata),
    .protocol_err_o (perr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: one outstanding granted request, a memory image,
  // and responses scheduled by absolute cycle number.
  logic [63:0] mmem [MEM];
  bit          m_pend;
  logic [11:0] m_idx;
  bit          m_err;
  bit          sv [int];
  logic [63:0] sd [int];
  int          cyc;

  logic        o_gnt, o_rv, o_err;
  logic [63:0] o_rd;

  int n_cmp;
  int n_bad;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_in();
    req_i = '0;
    blk   = 1'b0;
    pwe   = 1'b0;
    paddr = '0;
    pdata = '0;
    rst   = 1'b0;
  endtask

  // One clock cycle: sample and check outputs mid-cycle, advance model
  task automatic step(input bit do_chk = 1'b1);
    logic        e_gnt, e_rv;
    logic [63:0] e_rd;
    logic [55:0] a;
    int          w;
    @(negedge clk);
    e_rv  = sv.exists(cyc);
    e_rd  = e_rv ? sd[cyc] : 64'h0;
    e_gnt = req_i.data_req && !req_i.data_we && !blk && !rst &&
            (!m_pend || req_i.tag_valid || req_i.kill_req);
    o_gnt = req_o.data_gnt;
    o_rv  = req_o.data_rvalid;
    o_rd  = req_o.data_rdata;
    o_err = perr;
    if (do_chk) begin
      chk("gnt", 64'(o_gnt), 64'(e_gnt));
      chk("rvalid", 64'(o_rv), 64'(e_rv));
      chk("rdata", o_rd, e_rd);
      chk("protocol_err", 64'(o_err), 64'(m_err));
    end
    if (e_rv) begin
      sv.delete(cyc);
      sd.delete(cyc);
    end
    if (rst) begin
      m_pend = 1'b0;
      m_err  = 1'b0;
      sv.delete();
      sd.delete();
    end else begin
      if ((!m_pend && (req_i.tag_valid || req_i.kill_req)) ||
          (req_i.data_req && req_i.data_we)) m_err = 1'b1;
      if (m_pend && req_i.tag_valid && !req_i.kill_req) begin
        a = {req_i.address_tag, m_idx};
        w = int'((a >> 3) % 56'(MEM));
        sv[cyc + int'(LAT)] = 1'b1;
        sd[cyc + int'(LAT)] = mmem[w];
      end
      if (!m_pend || req_i.tag_valid || req_i.kill_req) m_pend = e_gnt;
      if (e_gnt) m_idx = req_i.address_index;
    end
    if (pwe) mmem[paddr] = pdata;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  typedef struct {
    logic [7:0]  pw;
    logic [63:0] pd;
    logic [11:0] idx;
    logic [43:0] tag;
    logic [63:0] exp_rd;
  } vec_t;

  vec_t vecs [5];

  logic [63:0] bb_d [7];
  logic        bb_g [7];
  logic        bb_v [7];
  int          rvcnt;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    m_pend = 1'b0;
    m_err  = 1'b0;
    m_idx  = '0;

    vecs[0] = '{pw: 8'h00, pd: 64'h0123_4567_89AB_CDEF, idx: 12'h007, tag: 44'h0,   exp_rd: 64'h0123_4567_89AB_CDEF};
    vecs[1] = '{pw: 8'hFF, pd: 64'hFFFF_0000_FFFF_0000, idx: 12'h7F8, tag: 44'hABC, exp_rd: 64'hFFFF_0000_FFFF_0000};
    vecs[2] = '{pw: 8'h80, pd: 64'h8000_0000_0000_0001, idx: 12'hC00, tag: 44'h1,   exp_rd: 64'h8000_0000_0000_0001};
    vecs[3] = '{pw: 8'h7F, pd: 64'h5A5A_A5A5_3C3C_C3C3, idx: 12'h3FD, tag: 44'h0,   exp_rd: 64'h5A5A_A5A5_3C3C_C3C3};
    vecs[4] = '{pw: 8'h11, pd: 64'h0000_0000_0000_0000, idx: 12'h08A, tag: 44'h7,   exp_rd: 64'h0000_0000_0000_0000};

    clear_in();
    rst = 1'b1;
    step(1'b0);
    step(1'b0);
    rst = 1'b0;

    // Fill the whole store; also covers the post-reset output state
    for (int w = 0; w < int'(MEM); w++) begin
      pwe   = 1'b1;
      paddr = 8'(w);
      pdata = {$urandom, $urandom};
      step();
    end
    clear_in();
    step();
    chk("reset gnt", 64'(o_gnt), 64'h0);
    chk("reset rvalid", 64'(o_rv), 64'h0);
    chk("reset perr", 64'(o_err), 64'h0);

    // Basic load with latency 2
    pwe = 1'b1; paddr = 8'd5; pdata = 64'hDEADBEEF_CAFEF00D;
    step();
    clear_in();
    req_i.data_req = 1'b1; req_i.address_index = 12'h028;
    step();
    chk("basic gnt", 64'(o_gnt), 64'h1);
    clear_in();
    req_i.tag_valid = 1'b1;
    step();
    chk("basic rv tag cycle", 64'(o_rv), 64'h0);
    clear_in();
    step();
    chk("basic rv +1", 64'(o_rv), 64'h0);
    step();
    chk("basic rv +2", 64'(o_rv), 64'h1);
    chk("basic rdata", o_rd, 64'hDEADBEEF_CAFEF00D);
    step();
    chk("basic rv +3", 64'(o_rv), 64'h0);

    // Back-to-back three loads
    for (int k = 1; k <= 3; k++) begin
      pwe = 1'b1; paddr = 8'(k); pdata = 64'hB2B0_0000_0000_0000 + 64'(k);
      step();
    end
    clear_in();
    for (int k = 0; k < 7; k++) begin
      clear_in();
      if (k < 3) begin
        req_i.data_req = 1'b1;
        req_i.address_index = 12'(8 * (k + 1));
      end
      if (k >= 1 && k <= 3) req_i.tag_valid = 1'b1;
      step();
      bb_g[k] = o_gnt;
      bb_v[k] = o_rv;
      bb_d[k] = o_rd;
    end
    for (int k = 0; k < 3; k++) begin
      chk("b2b gnt", 64'(bb_g[k]), 64'h1);
      chk("b2b rvalid", 64'(bb_v[k + 3]), 64'h1);
      chk("b2b rdata", bb_d[k + 3], 64'hB2B0_0000_0000_0000 + 64'(k + 1));
    end
    chk("b2b rv tail", 64'(bb_v[6]), 64'h0);

    // Kill with tag asserted: no response
    clear_in();
    req_i.data_req = 1'b1; req_i.address_index = 12'h030;
    step();
    chk("kill gnt", 64'(o_gnt), 64'h1);
    clear_in();
    req_i.kill_req = 1'b1; req_i.tag_valid = 1'b1;
    step();
    clear_in();
    rvcnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (o_rv) rvcnt++;
    end
    chk("kill no rvalid", 64'(rvcnt), 64'h0);
    chk("kill perr", 64'(o_err), 64'h0);

    // Grant blocked for three cycles
    req_i.data_req = 1'b1; req_i.address_index = 12'h040; blk = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("blocked gnt", 64'(o_gnt), 64'h0);
    end
    blk = 1'b0;
    step();
    chk("unblocked gnt", 64'(o_gnt), 64'h1);
    clear_in();
    req_i.tag_valid = 1'b1;
    step();
    clear_in();
    step();
    step();
    chk("unblocked rvalid", 64'(o_rv), 64'h1);

    // Table of single loads
    foreach (vecs[i]) begin
      clear_in();
      pwe = 1'b1; paddr = vecs[i].pw; pdata = vecs[i].pd;
      step();
      clear_in();
      req_i.data_req = 1'b1; req_i.address_index = vecs[i].idx;
      req_i.data_be = 8'h0F; req_i.data_size = 2'd1;
      step();
      clear_in();
      req_i.tag_valid = 1'b1; req_i.address_tag = vecs[i].tag;
      step();
      clear_in();
      step();
      step();
      chk("vec rvalid", 64'(o_rv), 64'h1);
      chk("vec rdata", o_rd, vecs[i].exp_rd);
    end

    // Read-before-write when a preload hits the word being read
    clear_in();
    pwe = 1'b1; paddr = 8'd9; pdata = 64'hAAAA_1111_AAAA_1111;
    step();
    clear_in();
    req_i.data_req = 1'b1; req_i.address_index = 12'h048;
    step();
    clear_in();
    req_i.tag_valid = 1'b1;
    pwe = 1'b1; paddr = 8'd9; pdata = 64'hBBBB_2222_BBBB_2222;
    step();
    clear_in();
    step();
    step();
    chk("rbw old data", o_rd, 64'hAAAA_1111_AAAA_1111);

    // Reset one cycle after tag acceptance drops the response
    pwe = 1'b1; paddr = 8'd6; pdata = 64'h0606_0606_6060_6060;
    step();
    clear_in();
    req_i.data_req = 1'b1; req_i.address_index = 12'h030;
    step();
    clear_in();
    req_i.tag_valid = 1'b1;
    step();
    clear_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
    rvcnt = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (o_rv) rvcnt++;
    end
    chk("reset drops rvalid", 64'(rvcnt), 64'h0);
    req_i.data_req = 1'b1; req_i.address_index = 12'h030;
    step();
    clear_in();
    req_i.tag_valid = 1'b1;
    step();
    clear_in();
    step();
    step();
    chk("store kept rvalid", 64'(o_rv), 64'h1);
    chk("store kept rdata", o_rd, 64'h0606_0606_6060_6060);

    // Store request is refused and sets the sticky error
    clear_in();
    req_i.data_req = 1'b1; req_i.data_we = 1'b1;
    step();
    chk("store gnt", 64'(o_gnt), 64'h0);
    chk("store perr same cycle", 64'(o_err), 64'h0);
    clear_in();
    step();
    chk("store perr next", 64'(o_err), 64'h1);
    step();
    step();
    chk("store perr sticky", 64'(o_err), 64'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("perr cleared", 64'(o_err), 64'h0);

    // Tag in idle is a violation
    req_i.tag_valid = 1'b1;
    step();
    clear_in();
    step();
    chk("idle tag perr", 64'(o_err), 64'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      clear_in();
      rst                 = ($urandom % 64) == 0;
      req_i.data_req      = $urandom % 2;
      req_i.data_we       = ($urandom % 16) == 0;
      req_i.address_index = 12'($urandom_range(0, 127)) | (($urandom % 4 == 0) ? 12'h800 : 12'h000);
      req_i.address_tag   = 44'($urandom % 4);
      req_i.tag_valid     = ($urandom % 3) != 0;
      req_i.kill_req      = ($urandom % 8) == 0;
      req_i.data_be       = 8'($urandom);
      req_i.data_size     = 2'($urandom);
      req_i.data_wdata    = {$urandom, $urandom};
      blk                 = ($urandom % 5) == 0;
      pwe                 = ($urandom % 3) == 0;
      paddr               = 8'($urandom % 16);
      pdata               = {$urandom, $urandom};
      step();
    end
    clear_in();
    for (int k = 0; k < 4; k++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
